bless_local_nic: RTL
====================

Name: bless_local_nic

Overview:
- Network interface between a processing core and the local port of a BLESS router.
- Injection side:
  - Queues core packets in a small FIFO.
  - Builds local-port flits with destination and sequence fields.
  - Injects a flit only when the router has a free input slot (BLESS injection rule).
- Ejection side: registers flits leaving the router's local port and checks that they are addressed to this node.

Parameters:
X_W, 3, destination/local X coordinate width
Y_W, 3, destination/local Y coordinate width
SEQ_W, 8, sequence-number width
DATA_W, 32, payload width
DEPTH, 4, injection FIFO depth (power of two, >=2)
STARVE_TH, 16, starvation threshold in cycles
FLIT_W, 1+X_W+Y_W+SEQ_W+DATA_W, local flit width; layout {valid, dst_x, dst_y, seq, data}, MSB first; global.v local-port field positions equal this layout

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
local_x  input  X_W  this node's X coordinate (static)
local_y  input  Y_W  this node's Y coordinate (static)
core_req_valid  input  1  core offers a packet
core_req_ready  output  1  NIC accepts packet this cycle
core_req_dst_x  input  X_W  packet destination X
core_req_dst_y  input  Y_W  packet destination Y
core_req_data  input  DATA_W  packet payload
port_busy  input  4  valid bits of router inputs {N,S,E,W} this cycle
inj_flit  output  FLIT_W  flit driven to router local input
ej_flit  input  FLIT_W  flit from router local output
ej_valid  output  1  registered ejected flit valid
ej_seq  output  SEQ_W  sequence number of last ejected flit
ej_data  output  DATA_W  payload of last ejected flit
starve  output  1  injection starved for >= STARVE_TH cycles
dst_err  output  1  sticky: a misrouted flit was ejected
inj_count  output  16  flits injected, wraps
ej_count  output  16  flits ejected, wraps

Behaviour:
- Reset, synchronous, any cycle including mid-transfer:
  - FIFO emptied; contents are discarded.
  - seq counter = 0; starve counter = 0.
  - ej_valid, ej_seq, ej_data, dst_err, inj_count, ej_count = 0.
  - core_req_ready = 0 while reset is high.
- FIFO accept:
  - core_req_ready = !full && !reset. It does not depend on a same-cycle pop.
  - Push on clock edge when core_req_valid && core_req_ready. Stored entry is {dst_x, dst_y, data}.
- Inject condition: inj_ok = !empty && (port_busy != 4'b1111).
- inj_flit is combinational:
  - When inj_ok: {1'b1, head.dst_x, head.dst_y, seq, head.data}.
  - Otherwise: all zeros.
  - Latency: a packet pushed at edge T can first be injected in the cycle after T, with zero added delay.
- On an edge with inj_ok:
  - Pop the FIFO head.
  - seq <= seq+1, wrapping mod 2^SEQ_W.
  - inj_count <= inj_count+1, wrapping.
- Push and pop in the same cycle (not full): both occur and occupancy is unchanged. When full, no push occurs even if a pop happens.
- Starve counter:
  - Increments when !empty && port_busy==4'b1111, saturating at STARVE_TH.
  - Clears to 0 on any injection or when the FIFO is empty.
  - starve = (counter >= STARVE_TH), registered.
- Ejection, one-cycle register:
  - ej_valid <= ej_flit valid bit.
  - When the valid bit is set: ej_seq/ej_data <= fields; ej_count <= ej_count+1.
  - When clear: ej_seq/ej_data hold their values.
- dst_err <= dst_err | (valid && (dst_x!=local_x || dst_y!=local_y)). Cleared only by reset.
- Injection and ejection paths are independent; simultaneous events on both sides are legal.

Test Plan:
- Reset, then local=(2,1): push (3,1,0xA5A5A5A5) with port_busy=0 -> next cycle inj_flit={1,3,1,0x00,0xA5A5A5A5}; inj_count=1 after the edge; seq=1.
- Push 4 packets with port_busy=4'b1111 -> core_req_ready=0 after the 4th push, inj_flit=0. Release port_busy=4'b0111 -> flits emerge in order with seq 0,1,2,3, one per cycle; ready returns after the first pop.
- Hold port_busy=4'b1111 with 1 queued for 16 cycles -> starve=1 on the 17th cycle. One free port -> injection occurs and starve=0 the next cycle.
- ej_flit={1,2,1,0x07,0xDEADBEEF} for one cycle at local (2,1) -> next cycle ej_valid=1, ej_seq=7, ej_data=0xDEADBEEF, ej_count=1, dst_err=0. Then a flit to (0,0) -> dst_err=1 and it stays set.
- Inject 256 flits -> seq wraps to 0 on the 257th flit.
- Assert reset while FIFO holds 3 entries -> FIFO empty next cycle and inj_flit=0. dst_err/counts are 0; core_req_ready=1 after reset deasserts.

Source files
------------

// File: rtl/bless_local_nic.sv
// Core-to-router network interface for the local port of a BLESS (bufferless) router.
// Queues core packets, injects flits when a router input slot is free, and registers ejected flits.
module bless_local_nic #(
    parameter int X_W       = 3,
    parameter int Y_W       = 3,
    parameter int SEQ_W     = 8,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int STARVE_TH = 16,
    parameter int FLIT_W    = 1 + X_W + Y_W + SEQ_W + DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [X_W-1:0]    local_x,
    input  logic [Y_W-1:0]    local_y,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [X_W-1:0]    core_req_dst_x,
    input  logic [Y_W-1:0]    core_req_dst_y,
    input  logic [DATA_W-1:0] core_req_data,
    input  logic [3:0]        port_busy,
    output logic [FLIT_W-1:0] inj_flit,
    input  logic [FLIT_W-1:0] ej_flit,
    output logic              ej_valid,
    output logic [SEQ_W-1:0]  ej_seq,
    output logic [DATA_W-1:0] ej_data,
    output logic              starve,
    output logic              dst_err,
    output logic [15:0]       inj_count,
    output logic [15:0]       ej_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = X_W + Y_W + DATA_W;
    localparam int CNT_W   = $clog2(STARVE_TH + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_TH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [ENTRY_W-1:0] head;
    logic               empty, full, all_busy, inj_ok, push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head     = mem[rd_ptr_q[PTR_W-1:0]];
    assign all_busy = &port_busy;
    assign inj_ok   = !empty && !all_busy;

    assign core_req_ready = !full && !reset;
    assign push           = core_req_valid && core_req_ready;

    always_comb begin
        inj_flit = '0;
        if (inj_ok) begin
            inj_flit = {1'b1, head[ENTRY_W-1:DATA_W], seq_q, head[DATA_W-1:0]};
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (!empty && all_busy) begin
            starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= {core_req_dst_x, core_req_dst_y, core_req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            seq_q        <= '0;
            inj_count    <= '0;
            starve_cnt_q <= '0;
            starve       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (inj_ok) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                seq_q     <= seq_q + 1'b1;
                inj_count <= inj_count + 1'b1;
            end
            starve_cnt_q <= starve_cnt_d;
            starve       <= (starve_cnt_d >= STARVE_LIM);
        end
    end

    logic              ej_v;
    logic [X_W-1:0]    ej_dx;
    logic [Y_W-1:0]    ej_dy;
    logic [SEQ_W-1:0]  ej_sq;
    logic [DATA_W-1:0] ej_dt;

    assign ej_v  = ej_flit[FLIT_W-1];
    assign ej_dx = ej_flit[FLIT_W-2 -: X_W];
    assign ej_dy = ej_flit[FLIT_W-2-X_W -: Y_W];
    assign ej_sq = ej_flit[DATA_W +: SEQ_W];
    assign ej_dt = ej_flit[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ej_valid <= 1'b0;
            ej_seq   <= '0;
            ej_data  <= '0;
            ej_count <= '0;
            dst_err  <= 1'b0;
        end else begin
            ej_valid <= ej_v;
            if (ej_v) begin
                ej_seq   <= ej_sq;
                ej_data  <= ej_dt;
                ej_count <= ej_count + 1'b1;
                if ((ej_dx != local_x) || (ej_dy != local_y)) begin
                    dst_err <= 1'b1;
                end
            end
        end
    end

endmodule
